// File: rtl/coef_rom_pipe.sv
// Multi-port coefficient ROM returning 8x8 row or transposed column words through a
// stallable LAT-deep read pipeline, with optional 8-beat wrapping bursts per port.
module coef_rom_pipe #(
    parameter int NPORT = 2,
    parameter int LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic [NPORT-1:0]      req_valid,
    input  logic [3*NPORT-1:0]    req_addr,
    input  logic [NPORT-1:0]      req_col,
    input  logic [NPORT-1:0]      req_burst,
    output logic [NPORT-1:0]      busy,
    output logic [64*NPORT-1:0]   dout,
    output logic [NPORT-1:0]      dout_valid,
    output logic [3*NPORT-1:0]    dout_idx,
    output logic [NPORT-1:0]      dout_col
);

    if (NPORT < 1 || NPORT > 4) begin : g_bad_nport
        $error("coef_rom_pipe: NPORT must be in 1..4");
    end
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("coef_rom_pipe: LAT must be in 1..4");
    end

    function automatic logic [63:0] row_word(input logic [2:0] r);
        logic [63:0] w;
        case (r)
            3'd0:    w = 64'h5B5B5B5B5B5B5B5B;
            3'd1:    w = 64'h7E6A4719E7B99682;
            3'd2:    w = 64'h7631CF8A8ACF3176;
            3'd3:    w = 64'h6AE782B9477E1996;
            3'd4:    w = 64'h5BA5A55B5BA5A55B;
            3'd5:    w = 64'h4782196A96E77EB9;
            3'd6:    w = 64'h318A76CFCF768A31;
            3'd7:    w = 64'h19B96A827E9647E7;
            default: w = 64'h0000000000000000;
        endcase
        return w;
    endfunction

    // Column c gathers byte c of every row, row 0 landing in the MSB byte.
    function automatic logic [63:0] col_word(input logic [2:0] c);
        logic [63:0] w;
        logic [63:0] rw;
        w = 64'h0000000000000000;
        for (int r = 0; r < 8; r++) begin
            rw = row_word(3'(r));
            w[63-8*r -: 8] = rw[63-8*int'(c) -: 8];
        end
        return w;
    endfunction

    function automatic logic [63:0] coef_word(input logic [2:0] idx, input logic col);
        logic [63:0] w;
        if (col) begin
            w = col_word(idx);
        end else begin
            w = row_word(idx);
        end
        return w;
    endfunction

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic                  busy_q, busy_d;
        logic [2:0]            bidx_q, bidx_d;
        logic                  bcol_q, bcol_d;
        logic [2:0]            bleft_q, bleft_d;
        logic                  iss_v_s;
        logic [2:0]            iss_idx_s;
        logic                  iss_col_s;
        logic [LAT-1:0]        pv_q;
        logic [LAT-1:0][2:0]   pidx_q;
        logic [LAT-1:0]        pcol_q;
        logic [LAT-1:0][63:0]  pdat_q;

        // Issue selection: an active burst owns the port, otherwise a new request is taken.
        always_comb begin
            busy_d    = busy_q;
            bidx_d    = bidx_q;
            bcol_d    = bcol_q;
            bleft_d   = bleft_q;
            iss_v_s   = 1'b0;
            iss_idx_s = 3'd0;
            iss_col_s = 1'b0;
            if (busy_q) begin
                iss_v_s   = 1'b1;
                iss_idx_s = bidx_q;
                iss_col_s = bcol_q;
                bidx_d    = bidx_q + 3'd1;
                bleft_d   = bleft_q - 3'd1;
                busy_d    = (bleft_q != 3'd1);
            end else if (req_valid[p]) begin
                iss_v_s   = 1'b1;
                iss_idx_s = req_addr[3*p +: 3];
                iss_col_s = req_col[p];
                if (req_burst[p]) begin
                    busy_d  = 1'b1;
                    bidx_d  = req_addr[3*p +: 3] + 3'd1;
                    bcol_d  = req_col[p];
                    bleft_d = 3'd7;
                end else begin
                    busy_d  = 1'b0;
                end
            end else begin
                iss_v_s = 1'b0;
            end
        end

        // Burst state and read pipeline; everything freezes while stall is high.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy_q  <= 1'b0;
                bidx_q  <= 3'd0;
                bcol_q  <= 1'b0;
                bleft_q <= 3'd0;
                pv_q    <= '0;
                pidx_q  <= '0;
                pcol_q  <= '0;
                pdat_q  <= '0;
            end else if (!stall) begin
                busy_q    <= busy_d;
                bidx_q    <= bidx_d;
                bcol_q    <= bcol_d;
                bleft_q   <= bleft_d;
                pv_q[0]   <= iss_v_s;
                pidx_q[0] <= iss_v_s ? iss_idx_s : 3'd0;
                pcol_q[0] <= iss_v_s ? iss_col_s : 1'b0;
                pdat_q[0] <= iss_v_s ? coef_word(iss_idx_s, iss_col_s) : 64'h0000000000000000;
                for (int i = 1; i < LAT; i++) begin
                    pv_q[i]   <= pv_q[i-1];
                    pidx_q[i] <= pidx_q[i-1];
                    pcol_q[i] <= pcol_q[i-1];
                    pdat_q[i] <= pdat_q[i-1];
                end
            end
        end

        assign busy[p]             = busy_q;
        assign dout[64*p +: 64]    = pdat_q[LAT-1];
        assign dout_valid[p]       = pv_q[LAT-1];
        assign dout_idx[3*p +: 3]  = pidx_q[LAT-1];
        assign dout_col[p]         = pcol_q[LAT-1];
    end

endmodule

// File: tb/tb_coef_rom_pipe.sv
// Bench for coef_rom_pipe: directed and random traffic on a 2-port/LAT=2 instance checked
// against a queue-style reference model, plus a directed 4-port/LAT=4 instance.
module tb_coef_rom_pipe;
    localparam int NP = 2;
    localparam int LT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic [1:0]    req_valid, req_col, req_burst;
    logic [5:0]    req_addr;
    logic [1:0]    busy, dout_valid, dout_col;
    logic [127:0]  dout;
    logic [5:0]    dout_idx;

    logic          b_stall;
    logic [3:0]    b_valid, b_col, b_burst, b_busy, b_dv, b_dcol;
    logic [11:0]   b_addr, b_idx;
    logic [255:0]  b_dout;

    int nchecks = 0;
    int nerr    = 0;

    int pend  [NP][8];
    int npend [NP];
    int pcol  [NP];
    int dl    [NP][LT];

    always #5 clk = ~clk;

    coef_rom_pipe #(.NPORT(2), .LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .req_valid(req_valid), .req_addr(req_addr),
        .req_col(req_col), .req_burst(req_burst), .busy(busy), .dout(dout),
        .dout_valid(dout_valid), .dout_idx(dout_idx), .dout_col(dout_col)
    );

    coef_rom_pipe #(.NPORT(4), .LAT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(b_stall), .req_valid(b_valid), .req_addr(b_addr),
        .req_col(b_col), .req_burst(b_burst), .busy(b_busy), .dout(b_dout),
        .dout_valid(b_dv), .dout_idx(b_idx), .dout_col(b_dcol)
    );

    // Element (r,c) of the table taken straight from the listed row constants.
    function automatic logic [63:0] ref_word(input int idx, input int col);
        logic [63:0] rows [8];
        logic [63:0] w;
        int r, c;
        rows[0] = 64'h5B5B5B5B5B5B5B5B; rows[1] = 64'h7E6A4719E7B99682;
        rows[2] = 64'h7631CF8A8ACF3176; rows[3] = 64'h6AE782B9477E1996;
        rows[4] = 64'h5BA5A55B5BA5A55B; rows[5] = 64'h4782196A96E77EB9;
        rows[6] = 64'h318A76CFCF768A31; rows[7] = 64'h19B96A827E9647E7;
        w = 64'h0;
        for (int k = 0; k < 8; k++) begin
            r = (col != 0) ? k : idx;
            c = (col != 0) ? idx : k;
            w = (w << 8) | ((rows[r] >> (56 - 8*c)) & 64'hFF);
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            npend[p] = 0;
            pcol[p]  = 0;
            for (int i = 0; i < LT; i++) dl[p][i] = 0;
        end
    endtask

    // Items are encoded as valid<<4 | col<<3 | idx; dl[p][0] is what dout shows.
    task automatic model_edge();
        int item, a;
        if (!rst_n) begin
            model_reset();
        end else if (!stall) begin
            for (int p = 0; p < NP; p++) begin
                item = 0;
                if (npend[p] > 0) begin
                    item = 16 | (pcol[p] << 3) | pend[p][0];
                    for (int j = 0; j < 7; j++) pend[p][j] = pend[p][j+1];
                    npend[p]--;
                end else if (req_valid[p]) begin
                    a    = int'(req_addr[3*p +: 3]);
                    item = 16 | (int'(req_col[p]) << 3) | a;
                    if (req_burst[p]) begin
                        for (int j = 1; j < 8; j++) pend[p][j-1] = (a + j) % 8;
                        npend[p] = 7;
                        pcol[p]  = int'(req_col[p]);
                    end
                end
                for (int i = 0; i < LT - 1; i++) dl[p][i] = dl[p][i+1];
                dl[p][LT-1] = item;
            end
        end
    endtask

    task automatic check_all();
        int  e;
        logic v;
        for (int p = 0; p < NP; p++) begin
            e = dl[p][0];
            v = (e & 16) != 0;
            chk($sformatf("p%0d dout_valid", p), 64'(dout_valid[p]), 64'(v));
            chk($sformatf("p%0d busy", p), 64'(busy[p]), 64'(npend[p] > 0));
            chk($sformatf("p%0d dout", p), dout[64*p +: 64], v ? ref_word(e & 7, (e >> 3) & 1) : 64'h0);
            if (v) begin
                chk($sformatf("p%0d dout_idx", p), 64'(dout_idx[3*p +: 3]), 64'(e & 7));
                chk($sformatf("p%0d dout_col", p), 64'(dout_col[p]), 64'((e >> 3) & 1));
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        req_valid = 2'b00; req_col = 2'b00; req_burst = 2'b00; req_addr = 6'd0;
    endtask

    initial begin
        int nbeats, nbusy, seq_ok;
        rst_n = 1'b0; stall = 1'b0; idle();
        b_stall = 1'b0; b_valid = 4'h0; b_col = 4'h0; b_burst = 4'h0; b_addr = 12'd0;
        #2;
        model_reset();
        check_all();
        chk("b reset dout", b_dout[63:0] | b_dout[255:192], 64'h0);
        chk("b reset valid", 64'(b_dv), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single row read on port 0 right after reset release.
        req_valid = 2'b01; req_addr = 6'd1;
        tick(); idle();
        tick();
        chk("r029 dout", dout[63:0], 64'h7E6A4719E7B99682);
        chk("r029 valid", 64'(dout_valid[0]), 64'h1);
        tick();
        chk("r029 one beat", 64'(dout_valid[0]), 64'h0);

        // Column reads on port 1.
        req_valid = 2'b10; req_addr = {3'd1, 3'd0}; req_col = 2'b10;
        tick(); idle();
        tick();
        chk("r030 col1", dout[127:64], 64'h5B6A31E7A5828AB9);
        req_valid = 2'b10; req_addr = {3'd0, 3'd0}; req_col = 2'b10;
        tick(); idle();
        tick();
        chk("r030 col0", dout[127:64], 64'h5B7E766A5B473119);

        // Same index on both ports at once.
        req_valid = 2'b11; req_addr = {3'd5, 3'd5};
        tick(); idle();
        tick();
        chk("same idx p0", dout[63:0], 64'h4782196A96E77EB9);
        chk("same idx p1", dout[127:64], 64'h4782196A96E77EB9);

        // Burst from 6 with an ignored request while busy.
        req_valid = 2'b01; req_addr = 6'd6; req_burst = 2'b01;
        tick(); idle();
        nbeats = 0; nbusy = int'(busy[0]); seq_ok = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin req_valid = 2'b01; req_addr = 6'd2; end
            tick(); idle();
            if (dout_valid[0]) begin
                if (int'(dout_idx[2:0]) != (6 + nbeats) % 8) seq_ok = 0;
                nbeats++;
            end
            nbusy += int'(busy[0]);
        end
        chk("r031 beats", 64'(nbeats), 64'd8);
        chk("r031 seq", 64'(seq_ok), 64'd1);
        chk("r031 busy cycles", 64'(nbusy), 64'd7);

        // Stall for three cycles in the middle of a port 1 column burst.
        req_valid = 2'b10; req_addr = {3'd3, 3'd0}; req_col = 2'b10; req_burst = 2'b10;
        tick(); idle();
        tick(); tick();
        stall = 1'b1;
        tick(); tick(); tick();
        stall = 1'b0;
        for (int i = 0; i < 9; i++) tick();

        // Reset during a burst, then a single read.
        req_valid = 2'b01; req_addr = 6'd3; req_burst = 2'b01;
        tick(); idle();
        tick(); tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
        req_valid = 2'b01; req_addr = 6'd4;
        tick(); idle();
        tick();
        chk("r033 dout", dout[63:0], 64'h5BA5A55B5BA5A55B);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            stall     = ($urandom_range(0, 6) == 0);
            req_valid = 2'($urandom);
            req_addr  = 6'($urandom);
            req_col   = 2'($urandom);
            req_burst = 2'($urandom) & 2'($urandom) & 2'($urandom);
            tick();
        end
        stall = 1'b0; idle();
        for (int i = 0; i < 10; i++) tick();

        // Four ports, LAT=4, all reading index 7 together.
        b_valid = 4'hF; b_addr = {4{3'd7}};
        tick(); b_valid = 4'h0; b_addr = 12'd0;
        tick();
        chk("r034 early1", 64'(b_dv), 64'h0);
        tick();
        chk("r034 early2", 64'(b_dv), 64'h0);
        tick();
        chk("r034 valid", 64'(b_dv), 64'hF);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("r034 dout p%0d", p), b_dout[64*p +: 64], 64'h19B96A827E9647E7);
        end
        tick();
        chk("r034 one beat", 64'(b_dv), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/coef_rom_pipe.md
COEF_ROM_PIPE -- requirements
Module: coef_rom_pipe

Interface
REQ-001 The block SHALL have parameter NPORT, default 2, giving the number of independent read ports (legal 1..4).
REQ-002 The block SHALL have parameter LAT, default 2, giving the read latency in clock edges (legal 1..4); illegal NPORT or LAT values SHALL cause an elaboration error.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port stall, input, 1 bit: global pipeline freeze.
REQ-006 The block SHALL have port req_valid, input, NPORT bits: read request, one bit per port.
REQ-007 The block SHALL have port req_addr, input, 3*NPORT bits: row or column index; port p uses bits [3p+2:3p].
REQ-008 The block SHALL have port req_col, input, NPORT bits: 1 = return column (transposed) word, 0 = return row word.
REQ-009 The block SHALL have port req_burst, input, NPORT bits: 1 = 8-beat auto-increment burst.
REQ-010 The block SHALL have port busy, output, NPORT bits: port is mid-burst and cannot accept a request.
REQ-011 The block SHALL have port dout, output, 64*NPORT bits: coefficient word; port p uses bits [64p+63:64p].
REQ-012 The block SHALL have port dout_valid, output, NPORT bits: dout of that port is valid this cycle.
REQ-013 The block SHALL have port dout_idx, output, 3*NPORT bits: index that produced the current dout.
REQ-014 The block SHALL have port dout_col, output, NPORT bits: req_col value that produced the current dout.

Function
REQ-015 The table SHALL be fixed rows 0..7 = 5B5B5B5B5B5B5B5B, 7E6A4719E7B99682, 7631CF8A8ACF3176, 6AE782B9477E1996, 5BA5A55B5BA5A55B, 4782196A96E77EB9, 318A76CFCF768A31, 19B96A827E9647E7 (hex); element c of a row SHALL be bits [63-8c:56-8c].
REQ-016 Column word c SHALL be formed with element r = element c of row r, using the same packing (element 0 in MSB byte).
REQ-017 Port p SHALL accept a request at an edge where req_valid[p]=1, busy[p]=0 and stall=0; otherwise the request SHALL be dropped without effect.
REQ-018 With no stall, data for a request accepted at edge k SHALL appear on dout with dout_valid=1 for the cycle after edge k+LAT-1, i.e. visible exactly LAT edges after acceptance.
REQ-019 A single (non-burst) accept SHALL produce exactly one dout_valid beat.
REQ-020 A burst accept at index a SHALL issue indices a, a+1, ..., a+7 mod 8 on consecutive unstalled edges, with req_col captured once at accept.
REQ-021 Burst indices SHALL wrap from 7 to 0.
REQ-022 busy[p] SHALL be 1 from the edge after burst accept until the edge on which the eighth beat issues, and 0 otherwise.
REQ-023 While stall=1, pipeline registers, burst counters, busy, dout, dout_valid, dout_idx and dout_col SHALL hold their values.
REQ-024 Ports SHALL be fully independent; simultaneous requests to the same index on different ports SHALL each return the correct word at the same latency.
REQ-025 dout SHALL be 0 whenever dout_valid is 0 (bubble beats drive zero).

Reset
REQ-026 While rst_n=0, busy, dout, dout_valid, dout_idx, dout_col and all pipeline and burst state SHALL be 0 immediately, independent of clk.
REQ-027 Reset asserted mid-burst SHALL abort the burst; after release the port SHALL accept a new request on the first edge.
REQ-028 The block SHALL accept requests on the first rising edge after rst_n deasserts.

Verification
REQ-029 LAT=2: port 0 single row read, addr 1 -> dout[63:0]=7E6A4719E7B99682, dout_valid=1 two edges after accept, for one cycle only.
REQ-030 Column read, port 1, col=1 -> 5B6A31E7A5828AB9; col=0 -> 5B7E766A5B473119.
REQ-031 Burst from addr 6, row mode -> dout_idx 6,7,0,1,2,3,4,5 on consecutive cycles; busy high for 7 cycles; a req_valid pulse while busy is ignored.
REQ-032 Stall held 3 cycles mid-burst -> outputs frozen for those 3 cycles; sequence resumes with no lost or duplicated beat.
REQ-033 rst_n pulsed low during beat 3 of a burst -> all outputs 0 at once; after release, a single read of addr 4 returns 5BA5A55B5BA5A55B at LAT.
REQ-034 NPORT=4, LAT=4, all ports read addr 7 on the same edge -> all four dout slices equal 19B96A827E9647E7 four edges later.
